ucd_register: RTL and testbench
===============================

# ucd_register

Universal count-down register: a WIDTH-bit register with hold, shift-right, decrement and parallel-load modes. It is the down-counting counterpart of the universal up-counter cell chain in the counters/registers lab set. The mode encoding and carry-chain style match the up-counter cell, so up and down stages can sit side by side in the same datapath. A borrow output lets several instances cascade into wider down-counters.

## Interface
Parameters:
- WIDTH, 8, register width in bits (≥2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- min  input  2  mode: 00 hold, 01 shift right, 10 count down, 11 parallel load
- bin  input  1  borrow-in / count enable; decrement happens only in mode 10 with bin=1
- sin  input  1  serial input, shifted into the MSB in mode 01
- pin  input  WIDTH  parallel load value, used in mode 11
- q  output  WIDTH  register contents
- bout  output  1  borrow-out, combinational: bin & (min==10) & (q==0)
- sout  output  1  serial output, combinational: q[0]
- tc  output  1  registered terminal-count pulse

## Operation
- **Reset** (rst=1, asynchronous): q=0, tc=0, and the internal reload register rl=0, immediately, regardless of clk.
- **Mode 00, hold:** q unchanged; tc←0.
- **Mode 01, shift right:** q←{sin, q[WIDTH-1:1]}; tc←0. The old q[0] was visible on sout before the edge.
- **Mode 10, count down:**
  - bin=0: q unchanged; tc←0.
  - bin=1, q≠0: q←q−1; tc←0.
  - bin=1, q=0: underflow. q←all-ones without AUTO_RELOAD_EN, q←rl with it; tc←1 for exactly one cycle.
- **Mode 11, parallel load:** q←pin; rl←pin; tc←0. bin is ignored.
- Arithmetic is modulo 2^WIDTH. No intermediate result is wider than WIDTH.
- bout is purely combinational. It is 1 in the same cycle q==0 is being decremented, so it can drive bin of the next (more significant) stage.
- rl is written only by mode 11 and reset. Without AUTO_RELOAD_EN, rl may be optimised away.
- The mode value is sampled only at the clock edge. Glitches between edges affect only bout.

## Timing
- Every state change except reset takes one cycle: inputs are sampled at a rising edge, and q and tc are valid after that edge.
- tc is high in the cycle after the underflow edge and low again one edge later, unless another underflow occurs.
- bout and sout have zero latency from q, min and bin.
- Reset mid-operation: q, tc and rl clear asynchronously. The first edge with rst=0 applies the current mode to q=0. For example, mode 10 with bin=1 underflows on that edge and asserts tc.
- Load and count requests never coincide, because the mode is a single encoded field; no priority logic is needed.
- Cascading: chain N instances with stage k bin ← stage k−1 bout and stage 0 bin tied to the enable. All stages update on the same edge, and the combinational borrow ripples within the cycle.

## Configuration
- **AUTO_RELOAD_EN**
  - Defined: on underflow, q reloads from rl (the last parallel-loaded value, 0 after reset). This gives a programmable-period divider with period rl+1; tc marks each period.
  - Not defined: underflow wraps to all-ones (2^WIDTH−1), and rl is not instantiated.
  - The tc and bout behaviour is identical in both builds.

## Test plan
All scenarios use WIDTH=8.
- **Reset:** assert rst mid-cycle with q=0x5A → q=0x00 and tc=0 immediately, before the next edge.
- **Load then count:** min=11, pin=0x03; then min=10, bin=1 for 4 edges → q=0x02, 0x01, 0x00, then 0xFF (no macro). bout=1 during the q=0x00 cycle; tc=1 only in the cycle after the 0x00→0xFF edge.
- **Hold and enable:** min=10, bin=0 with q=0x10 for 3 edges → q stays 0x10, bout=0. Then min=00, bin=1 for 3 edges → q stays 0x10.
- **Shift:** load 0x81, then min=01, sin=1 for 2 edges → q=0xC0, then 0xE0. sout shows 1, then 0, then 0.
- **Auto reload** (build with AUTO_RELOAD_EN): load 0x02, then count with bin=1 for 6 edges → q=0x01, 0x00, 0x02, 0x01, 0x00, 0x02. tc pulses after the 3rd and 6th edges.
- **Cascade of two stages:** load low=0x00, high=0x01, then count one edge → low=0xFF, high=0x00. The low stage's bout=1 before the edge.

Source files
------------

// File: rtl/ucd_register.sv
// ucd_register: WIDTH-bit universal count-down register (hold/shift/down/load).
// Optional AUTO_RELOAD_EN: underflow reloads q from the last parallel-loaded value.
module ucd_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       min,
  input  logic             bin,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             bout,
  output logic             sout,
  output logic             tc
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_DOWN  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [WIDTH-1:0] LSB_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_tc_nxt;
  logic [WIDTH-1:0] w_reload;
  logic             w_zero;
  logic             w_uflow;

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_rl;

  // Reload value tracks every parallel load so underflow restarts the period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rl <= '0;
    end else if (min == MODE_LOAD) begin
      r_rl <= pin;
    end
  end

  assign w_reload = r_rl;
`else
  assign w_reload = '1;
`endif

  assign w_zero  = (r_q == '0);
  assign w_uflow = bin & (min == MODE_DOWN) & w_zero;

  // Next-state selection from the encoded mode field
  always_comb begin
    w_q_nxt  = r_q;
    w_tc_nxt = 1'b0;
    unique case (min)
      MODE_HOLD: begin
        w_q_nxt = r_q;
      end
      MODE_SHIFT: begin
        w_q_nxt = {sin, r_q[WIDTH-1:1]};
      end
      MODE_DOWN: begin
        if (bin) begin
          if (w_zero) begin
            w_q_nxt  = w_reload;
            w_tc_nxt = 1'b1;
          end else begin
            w_q_nxt = r_q - LSB_ONE;
          end
        end
      end
      MODE_LOAD: begin
        w_q_nxt = pin;
      end
      default: begin
        w_q_nxt = r_q;
      end
    endcase
  end

  // Register contents and one-cycle terminal-count pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q  <= '0;
      r_tc <= 1'b0;
    end else begin
      r_q  <= w_q_nxt;
      r_tc <= w_tc_nxt;
    end
  end

  assign q    = r_q;
  assign tc   = r_tc;
  assign bout = w_uflow;
  assign sout = r_q[0];

endmodule

// File: tb/tb_ucd_register.sv
// tb_ucd_register: randomized and directed checks of ucd_register (WIDTH=8)
// against an integer reference model; includes a two-stage cascade.
module tb_ucd_register;

  localparam int W = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic [1:0]   min;
  logic         bin;
  logic         sin;
  logic [W-1:0] pin;
  logic [W-1:0] q;
  logic         bout;
  logic         sout;
  logic         tc;

  logic [1:0]   c_min;
  logic         c_en;
  logic [W-1:0] c_pin_lo;
  logic [W-1:0] c_pin_hi;
  logic [W-1:0] c_q_lo;
  logic [W-1:0] c_q_hi;
  logic         c_bout_lo;
  logic         c_bout_hi;
  logic         c_sout_lo;
  logic         c_sout_hi;
  logic         c_tc_lo;
  logic         c_tc_hi;

  int n_chk;
  int n_err;

  int m_q;
  int m_tc;
  int m_rl;

  ucd_register #(.WIDTH(W)) u_dut (
    .clk (clk), .rst (rst), .min (min), .bin (bin),
    .sin (sin), .pin (pin), .q (q), .bout (bout),
    .sout(sout), .tc (tc)
  );

  ucd_register #(.WIDTH(W)) u_lo (
    .clk (clk), .rst (rst), .min (c_min), .bin (c_en),
    .sin (1'b0), .pin (c_pin_lo), .q (c_q_lo),
    .bout(c_bout_lo), .sout(c_sout_lo), .tc (c_tc_lo)
  );

  ucd_register #(.WIDTH(W)) u_hi (
    .clk (clk), .rst (rst), .min (c_min), .bin (c_bout_lo),
    .sin (1'b0), .pin (c_pin_hi), .q (c_q_hi),
    .bout(c_bout_hi), .sout(c_sout_hi), .tc (c_tc_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: behaviour stated in terms of integer arithmetic per edge
  task automatic model_edge(input int m, input int b, input int s,
                            input int p);
    int nq;
    int ntc;
    nq  = m_q;
    ntc = 0;
    if (m == 1) begin
      nq = ((s & 1) << (W - 1)) + (m_q / 2);
    end else if (m == 2 && b != 0) begin
      if (m_q == 0) begin
`ifdef AUTO_RELOAD_EN
        nq = m_rl;
`else
        nq = MASK;
`endif
        ntc = 1;
      end else begin
        nq = m_q - 1;
      end
    end else if (m == 3) begin
      nq   = p & MASK;
      m_rl = p & MASK;
    end
    m_q  = nq;
    m_tc = ntc;
  endtask

  task automatic step(input logic [1:0] m, input logic b, input logic s,
                      input logic [W-1:0] p);
    min = m;
    bin = b;
    sin = s;
    pin = p;
    #1;
    chk("bout", bout, (b && m == 2'b10 && m_q == 0) ? 1 : 0);
    chk("sout", sout, m_q & 1);
    @(posedge clk);
    model_edge(int'(m), int'(b), int'(s), int'(p));
    #1;
    chk("q", q, m_q);
    chk("tc", tc, m_tc);
  endtask

  // Asserts reset mid-cycle and checks the asynchronous clear
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_q_async", q, 0);
    chk("rst_tc_async", tc, 0);
    m_q  = 0;
    m_tc = 0;
    m_rl = 0;
    min  = 2'b00;
    bin  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_q_held", q, 0);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    m_q      = 0;
    m_tc     = 0;
    m_rl     = 0;
    rst      = 1'b1;
    min      = 2'b00;
    bin      = 1'b0;
    sin      = 1'b0;
    pin      = '0;
    c_min    = 2'b00;
    c_en     = 1'b0;
    c_pin_lo = '0;
    c_pin_hi = '0;

    @(posedge clk);
    #1;
    chk("reset_q", q, 0);
    chk("reset_tc", tc, 0);
    chk("reset_sout", sout, 0);
    #2;
    rst = 1'b0;

    // Load 3 then count four edges through underflow
    step(2'b11, 1'b0, 1'b0, 8'h03);
    step(2'b10, 1'b1, 1'b0, 8'h00);
    chk("cnt_02", q, 8'h02);
    step(2'b10, 1'b1, 1'b0, 8'h00);
    chk("cnt_01", q, 8'h01);
    step(2'b10, 1'b1, 1'b0, 8'h00);
    chk("cnt_00", q, 8'h00);
    chk("cnt_00_tc", tc, 0);
    step(2'b10, 1'b1, 1'b0, 8'h00);
`ifdef AUTO_RELOAD_EN
    chk("uflow_q", q, 8'h03);
`else
    chk("uflow_q", q, 8'hFF);
`endif
    chk("uflow_tc", tc, 1);
    step(2'b00, 1'b0, 1'b0, 8'h00);
    chk("tc_drop", tc, 0);

    // Reset while tc would be high
    step(2'b11, 1'b0, 1'b0, 8'h00);
    step(2'b10, 1'b1, 1'b0, 8'h00);
    mid_reset();

    // Reset with q=0x5A, then first edge underflows from zero
    step(2'b11, 1'b0, 1'b0, 8'h5A);
    chk("ld_5a", q, 8'h5A);
    mid_reset();
    step(2'b10, 1'b1, 1'b0, 8'h00);
    chk("post_rst_tc", tc, 1);

    // Hold with bin=0 in count mode, then hold mode with bin=1
    step(2'b11, 1'b0, 1'b0, 8'h10);
    for (int i = 0; i < 3; i++) step(2'b10, 1'b0, 1'b0, 8'h00);
    chk("hold_bin0", q, 8'h10);
    for (int i = 0; i < 3; i++) step(2'b00, 1'b1, 1'b0, 8'h00);
    chk("hold_mode", q, 8'h10);

    // Shift right from 0x81 with sin=1
    step(2'b11, 1'b0, 1'b0, 8'h81);
    step(2'b01, 1'b0, 1'b1, 8'h00);
    chk("shift_c0", q, 8'hC0);
    step(2'b01, 1'b0, 1'b1, 8'h00);
    chk("shift_e0", q, 8'hE0);
    chk("shift_sout", sout, 0);

    // Randomized mix, biased towards counting small values
    for (int i = 0; i < 400; i++) begin
      logic [1:0]   rm;
      logic [W-1:0] rp;
      rm = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) rm = 2'b10;
      rp = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 5));
      step(rm, 1'($urandom), 1'($urandom), rp);
    end

    // Two-stage cascade: 0x0100 - 1
    c_min    = 2'b11;
    c_pin_lo = 8'h00;
    c_pin_hi = 8'h01;
    @(posedge clk);
    #1;
    c_min = 2'b10;
    c_en  = 1'b1;
    #1;
    chk("casc_bout_lo", c_bout_lo, 1);
    chk("casc_bout_hi", c_bout_hi, 0);
    @(posedge clk);
    #1;
`ifdef AUTO_RELOAD_EN
    chk("casc_lo", c_q_lo, 8'h00);
`else
    chk("casc_lo", c_q_lo, 8'hFF);
`endif
    chk("casc_hi", c_q_hi, 8'h00);
    chk("casc_tc_lo", c_tc_lo, 1);
    c_min = 2'b00;
    c_en  = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
